// File: rtl/roi_scan_sequencer.sv
// ROI raster scan sequencer: one-hot row/column selects, settle dwell, ADC strobes, optional CDS.
// Optional build macro SCAN_SERPENTINE_EN alternates the column direction on every ROI row.
module roi_scan_sequencer #(
    parameter int NUM_ROW = 7,
    parameter int NUM_COL = 16,
    parameter int ROW_AW  = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1,
    parameter int COL_AW  = (NUM_COL > 1) ? $clog2(NUM_COL) : 1,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               single_pixel_en,
    input  logic [ROW_AW-1:0]  row_start,
    input  logic [ROW_AW-1:0]  row_stop,
    input  logic [COL_AW-1:0]  col_start,
    input  logic [COL_AW-1:0]  col_stop,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               cds_en,
    output logic [NUM_ROW-1:0] row_sel,
    output logic [NUM_COL-1:0] col_sel,
    output logic [ROW_AW-1:0]  pixel_row,
    output logic [COL_AW-1:0]  pixel_col,
    output logic               adc_start,
    output logic               cds_phase,
    output logic               busy,
    output logic               frame_done,
    output logic [2:0]         state_dbg
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] SETTLE  = 3'd2;
    localparam logic [2:0] CONVERT = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    localparam logic [ROW_AW-1:0] ROW_MAX = ROW_AW'(NUM_ROW - 1);
    localparam logic [COL_AW-1:0] COL_MAX = COL_AW'(NUM_COL - 1);

    logic [2:0]         state, state_nxt;
    logic [ROW_AW-1:0]  ld_row_start, ld_row_stop, cfg_row_stop, row_nxt;
    logic [COL_AW-1:0]  ld_col_start, ld_col_stop, cfg_col_start, cfg_col_stop, col_nxt;
    logic [COL_AW-1:0]  col_end;
    logic [DWELL_W-1:0] ld_dwell, cfg_dwell, cnt, cnt_nxt;
    logic               cfg_cds, phase_nxt, last_pixel, sel_on;

    assign state_dbg = state;

    // Bounds are normalised once at LOAD so the scan logic only ever sees a legal ROI.
    always_comb begin
        ld_row_start = (row_start > ROW_MAX) ? ROW_MAX : row_start;
        ld_row_stop  = (row_stop  > ROW_MAX) ? ROW_MAX : row_stop;
        if (single_pixel_en || (ld_row_stop < ld_row_start)) ld_row_stop = ld_row_start;
        ld_col_start = (col_start > COL_MAX) ? COL_MAX : col_start;
        ld_col_stop  = (col_stop  > COL_MAX) ? COL_MAX : col_stop;
        if (single_pixel_en || (ld_col_stop < ld_col_start)) ld_col_stop = ld_col_start;
        ld_dwell     = (dwell == '0) ? DWELL_W'(1) : dwell;
    end

`ifdef SCAN_SERPENTINE_EN
    logic [ROW_AW-1:0] cfg_row_start;
    logic              row_fwd;
    // Even ROI rows (relative to the first row) run forward, odd rows run backward.
    assign row_fwd = ~(pixel_row[0] ^ cfg_row_start[0]);
    assign col_end = row_fwd ? cfg_col_stop : cfg_col_start;
`else
    assign col_end = cfg_col_stop;
`endif

    assign last_pixel = (pixel_row == cfg_row_stop) && (pixel_col == col_end);

    always_comb begin
        state_nxt = state;
        row_nxt   = pixel_row;
        col_nxt   = pixel_col;
        phase_nxt = cds_phase;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (enable) state_nxt = LOAD;
            end
            LOAD: begin
                state_nxt = SETTLE;
                row_nxt   = ld_row_start;
                col_nxt   = ld_col_start;
                phase_nxt = ~cds_en;
                cnt_nxt   = '0;
            end
            SETTLE: begin
                if (cnt == cfg_dwell - DWELL_W'(1)) state_nxt = CONVERT;
                else cnt_nxt = cnt + DWELL_W'(1);
            end
            CONVERT: begin
                state_nxt = SETTLE;
                cnt_nxt   = '0;
                if (cfg_cds && !cds_phase) begin
                    phase_nxt = 1'b1;
                end else if (last_pixel) begin
                    state_nxt = DONE;
                end else begin
                    phase_nxt = ~cfg_cds;
`ifdef SCAN_SERPENTINE_EN
                    if (pixel_col == col_end) row_nxt = pixel_row + ROW_AW'(1);
                    else if (row_fwd) col_nxt = pixel_col + COL_AW'(1);
                    else col_nxt = pixel_col - COL_AW'(1);
`else
                    if (pixel_col == cfg_col_stop) begin
                        col_nxt = cfg_col_start;
                        row_nxt = pixel_row + ROW_AW'(1);
                    end else begin
                        col_nxt = pixel_col + COL_AW'(1);
                    end
`endif
                end
            end
            DONE: begin
                state_nxt = enable ? LOAD : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Dropping enable abandons the frame from any active state.
        if ((state != IDLE) && !enable) state_nxt = IDLE;
    end

    assign sel_on = (state_nxt == SETTLE) || (state_nxt == CONVERT);

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            pixel_row     <= '0;
            pixel_col     <= '0;
            cds_phase     <= 1'b0;
            cnt           <= '0;
            cfg_row_stop  <= '0;
            cfg_col_start <= '0;
            cfg_col_stop  <= '0;
            cfg_dwell     <= '0;
            cfg_cds       <= 1'b0;
`ifdef SCAN_SERPENTINE_EN
            cfg_row_start <= '0;
`endif
            row_sel       <= '0;
            col_sel       <= '0;
            adc_start     <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            state     <= state_nxt;
            pixel_row <= row_nxt;
            pixel_col <= col_nxt;
            cds_phase <= phase_nxt;
            cnt       <= cnt_nxt;
            if (state == LOAD) begin
                cfg_row_stop  <= ld_row_stop;
                cfg_col_start <= ld_col_start;
                cfg_col_stop  <= ld_col_stop;
                cfg_dwell     <= ld_dwell;
                cfg_cds       <= cds_en;
`ifdef SCAN_SERPENTINE_EN
                cfg_row_start <= ld_row_start;
`endif
            end
            row_sel    <= sel_on ? (NUM_ROW'(1) << row_nxt) : '0;
            col_sel    <= sel_on ? (NUM_COL'(1) << col_nxt) : '0;
            adc_start  <= (state_nxt == CONVERT);
            busy       <= (state_nxt != IDLE);
            frame_done <= (state_nxt == DONE);
        end
    end

endmodule
